fb_rect_fill: RTL and testbench
===============================

FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line (framebuffer row pitch).
REQ-002 Parameter V_RES, default 480, active lines per frame.
REQ-003 clk  input  1  single clock of the block, also used for framebuffer write port A.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  rectangle command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_x0 / cmd_x1  input  10 each  inclusive left/right pixel column.
REQ-008 cmd_y0 / cmd_y1  input  9 each  inclusive top/bottom pixel row.
REQ-009 cmd_color  input  12  RGB444 fill colour, {R,G,B}.
REQ-010 mem_addr  output  19  framebuffer word address, y*H_RES+x.
REQ-011 mem_data  output  16  write data, {4'b0, colour}.
REQ-012 mem_en  output  1  port enable, asserted only with mem_we.
REQ-013 mem_we  output  1  write strobe, one pixel per asserted cycle.
REQ-014 busy  output  1  high from command accept until done.
REQ-015 done  output  1  single-cycle pulse after the last write of a command.

Function
REQ-016 States IDLE, SETUP, FILL, FINISH; only IDLE asserts cmd_ready.
REQ-017 Handshake: command accepted on the rising edge where cmd_valid && cmd_ready; all cmd_* fields are registered at that edge and may change afterwards.
REQ-018 Clipping at accept: x1 clamped to H_RES-1, y1 clamped to V_RES-1; x0 >= H_RES or y0 >= V_RES, or x0 > x1 or y0 > y1 after clamping, marks the command empty.
REQ-019 IDLE -> SETUP on accept; SETUP lasts exactly one cycle, computes row base y0*H_RES with shift-add only (no multiplier inference), and sets the x counter to x0.
REQ-020 SETUP -> FINISH for an empty command (zero writes); otherwise SETUP -> FILL.
REQ-021 FILL writes one pixel per cycle, raster order: x increments x0..x1; at x1, x reloads x0, y increments, row base increments by H_RES.
REQ-022 FILL -> FINISH in the cycle the pixel (x1,y1) is written; FINISH asserts done for one cycle, then -> IDLE.
REQ-023 Total command latency: accept edge + 1 SETUP + W*H FILL + 1 FINISH cycles; cmd_ready returns high the cycle after done.
REQ-024 mem_addr/mem_data/mem_we/mem_en are registered outputs, all valid in the same cycle; mem_we=mem_en=0 outside FILL.
REQ-025 Address arithmetic is 19 bits and never wraps for clipped coordinates; max address (V_RES*H_RES)-1 = 307199 at defaults.
REQ-026 cmd_valid asserted while busy is ignored (no queueing); the command is taken when cmd_ready rises if still valid.
REQ-027 busy = (state != IDLE); done and busy are never high together except in FINISH.

Reset
REQ-028 rstn low asynchronously forces IDLE; cmd_ready=1, busy=0, done=0, mem_we=0, mem_en=0, mem_addr=0, mem_data=0, counters 0.
REQ-029 Reset mid-FILL aborts the command with no further writes and no done pulse; partially written pixels are left in memory.
REQ-030 Reset release is not self-synchronised inside the block; the first command may be accepted on the first edge after rstn rises.

Structure
REQ-031 H_RES, V_RES, ADDR_W=19, DATA_W=16 and the state encoding belong in the shared VGA package alongside the timing constants used by the display path.
REQ-032 One sub-module is natural: fb_addr_gen (x/y counters, row base, end-of-rect detect); the FSM and handshake stay in fb_rect_fill.
REQ-033 Outputs connect directly to framebuffer port A (addra, dina, wea, ena), clocked by the same clk.

Verification
REQ-034 Single pixel: (3,2)-(3,2), colour 12'hF00 -> one write, addr 1283, data 16'h0F00, done 3 cycles after accept.
REQ-035 Row wrap: (638,0)-(639,1), 12'h0F0 -> writes at 638, 639, 1278, 1279 in consecutive cycles, then done.
REQ-036 Clip: (630,470)-(1000,511) -> x1=639, y1=479; 100 writes, last addr 307199, no write above.
REQ-037 Empty: x0=5,x1=4 and separately x0=700 -> zero writes, done 2 cycles after accept, cmd_ready high next cycle.
REQ-038 Back-to-back: cmd_valid held high with two commands -> second accepted the cycle after first done; cmd_valid pulses during busy produce no writes.
REQ-039 Reset mid-FILL on a 10x10 fill after 37 writes -> writes stop at the asserting edge, no done, all outputs at reset values; a new command then completes normally.

Source files
------------

// File: rtl/fb_rect_fill_pkg.sv
// Shared VGA/framebuffer definitions: resolution, bus widths, fill FSM states, row-base helper.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package fb_rect_fill_pkg;

    // Active area of the 640x480@60 display mode; also the framebuffer geometry.
    localparam int FB_H_RES = 640;
    localparam int FB_V_RES = 480;

    // Blanking/sync timing used by the display scan-out path.
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 16;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int COLOR_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_FILL   = 2'd2,
        ST_FINISH = 2'd3
    } fill_state_t;

    // y * pitch as a sum of shifted copies of y. With a constant pitch every
    // term is a fixed shift, so this folds to a few adders and never infers a
    // multiplier.
    function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0]    y,
                                                   input logic [ADDR_W-1:0] pitch);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (pitch[i]) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Rectangle raster walker: x/y counters, row base and framebuffer address, end-of-rect flag.
// Latency: address registered one edge after load/step; last is combinational from the counters.
// Backpressure: none; advances only when the owner asserts step.
//
// Ports: load   - take x0/y0 as the first pixel (row base computed here)
//        step   - move to the next pixel in raster order; never stepped past the last pixel
//        x0..y1 - inclusive, already-clipped rectangle bounds (held stable by the owner)
//        last   - current pixel is (x1,y1)
//        addr   - word address of the current pixel, y*H_RES+x
module fb_addr_gen
    import fb_rect_fill_pkg::*;
#(
    parameter int H_RES = FB_H_RES
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              step,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    x1,
    input  logic [Y_W-1:0]    y0,
    input  logic [Y_W-1:0]    y1,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(H_RES);

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] load_base;

    assign load_base = row_base(y0, PITCH);
    assign last      = (x == x1) && (y == y1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x    <= '0;
            y    <= '0;
            base <= '0;
            addr <= '0;
        end else if (load) begin
            x    <= x0;
            y    <= y0;
            base <= load_base;
            addr <= load_base + ADDR_W'(x0);
        end else if (step) begin
            if (x == x1) begin
                // End of row: back to the left edge of the next line.
                x    <= x0;
                y    <= y + 1'b1;
                base <= base + PITCH;
                addr <= base + PITCH + ADDR_W'(x0);
            end else begin
                x    <= x + 1'b1;
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Solid rectangle fill into the framebuffer, one pixel write per cycle in raster order.
// Latency: accept edge + 1 setup + W*H fill + 1 finish cycle (done pulses in the finish cycle).
// Backpressure: cmd_ready only in IDLE; commands presented while busy are not queued.
//
// Ports: cmd_valid/cmd_ready + cmd_x0/x1/y0/y1/color - rectangle command handshake
//        mem_addr/mem_data/mem_en/mem_we              - framebuffer port A (registered)
//        busy                                          - command in progress
//        done                                          - one-cycle pulse after the last write
module fb_rect_fill
    import fb_rect_fill_pkg::*;
#(
    parameter int H_RES = FB_H_RES,
    parameter int V_RES = FB_V_RES
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x0,
    input  logic [X_W-1:0]     cmd_x1,
    input  logic [Y_W-1:0]     cmd_y0,
    input  logic [Y_W-1:0]     cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_data,
    output logic               mem_en,
    output logic               mem_we,
    output logic               busy,
    output logic               done
);

    localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

    fill_state_t        state;
    logic [X_W-1:0]     x0_r, x1_r;
    logic [Y_W-1:0]     y0_r, y1_r;
    logic [COLOR_W-1:0] color_r;
    logic               empty_r;
    logic               we_r;
    logic [DATA_W-1:0]  data_r;
    logic               done_r;

    logic [X_W-1:0]     x1_clip;
    logic [Y_W-1:0]     y1_clip;
    logic               cmd_empty;
    logic               last;

    // Clip the far corner to the screen; anything starting off-screen or
    // inverted after clipping produces no writes.
    always_comb begin
        x1_clip   = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        y1_clip   = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        cmd_empty = (cmd_x0 > X_MAX) || (cmd_y0 > Y_MAX) ||
                    (cmd_x0 > x1_clip) || (cmd_y0 > y1_clip);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            x0_r    <= '0;
            x1_r    <= '0;
            y0_r    <= '0;
            y1_r    <= '0;
            color_r <= '0;
            empty_r <= 1'b0;
            we_r    <= 1'b0;
            data_r  <= '0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        x0_r    <= cmd_x0;
                        x1_r    <= x1_clip;
                        y0_r    <= cmd_y0;
                        y1_r    <= y1_clip;
                        color_r <= cmd_color;
                        empty_r <= cmd_empty;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    data_r <= {{(DATA_W - COLOR_W){1'b0}}, color_r};
                    if (empty_r) begin
                        done_r <= 1'b1;
                        state  <= ST_FINISH;
                    end else begin
                        // The address generator loads the first pixel on this
                        // same edge, so the strobe lines up with it.
                        we_r  <= 1'b1;
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (last) begin
                        we_r   <= 1'b0;
                        done_r <= 1'b1;
                        state  <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fb_addr_gen #(
        .H_RES (H_RES)
    ) u_addr_gen (
        .clk   (clk),
        .rstn  (rstn),
        .load  (state == ST_SETUP),
        .step  ((state == ST_FILL) && !last),
        .x0    (x0_r),
        .x1    (x1_r),
        .y0    (y0_r),
        .y1    (y1_r),
        .last  (last),
        .addr  (mem_addr)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = done_r;
    assign mem_we    = we_r;
    assign mem_en    = we_r;
    assign mem_data  = data_r;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: hand-computed addresses, write counts and latencies.
// Latency: n/a.
// Backpressure: commands are held until cmd_ready is seen.
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0, cmd_x1 = '0;
    logic [8:0]  cmd_y0 = '0, cmd_y1 = '0;
    logic [11:0] cmd_color = '0;
    logic [18:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_en, mem_we, busy, done;

    fb_rect_fill dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_x1    (cmd_x1),
        .cmd_y0    (cmd_y0),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int en_err = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_we) begin
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(int'(mem_data));
                wr_cyc.push_back(cyc);
            end
            if (done) done_q.push_back(cyc);
            if (mem_en !== mem_we) en_err++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_q.delete();
    endtask

    // acc = cycle number of the cycle in which the command was accepted.
    task automatic issue(input int x0, input int x1, input int y0, input int y1,
                         input int col, input bit hold, output int acc);
        @(negedge clk);
        cmd_x0    = 10'(x0);
        cmd_x1    = 10'(x1);
        cmd_y0    = 9'(y0);
        cmd_y1    = 9'(y1);
        cmd_color = 12'(col);
        cmd_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 400; k++) begin
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int d);
        int n;
        n = done_q.size();
        d = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (done_q.size() > n) begin
                d = done_q[n];
                break;
            end
        end
        if (d < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(cmd_ready), 1);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_we"},    int'(mem_we), 0);
        chk({tag, "_en"},    int'(mem_en), 0);
        chk({tag, "_addr"},  int'(mem_addr), 0);
        chk({tag, "_data"},  int'(mem_data), 0);
    endtask

    task automatic single_pixel(input string tag);
        int acc, d;
        clear_log();
        issue(3, 3, 2, 2, 'hF00, 1'b0, acc);
        wait_done(d);
        chk({tag, "_busy_in_done"}, int'(busy), 1);
        chk({tag, "_nwr"}, wr_addr.size(), 1);
        chk({tag, "_addr"}, wr_addr.size() > 0 ? wr_addr[0] : -1, 1283);
        chk({tag, "_data"}, wr_data.size() > 0 ? wr_data[0] : -1, 'h0F00);
        chk({tag, "_wr_lat"}, wr_cyc.size() > 0 ? wr_cyc[0] - acc : -1, 2);
        chk({tag, "_done_lat"}, d - acc, 3);
        @(negedge clk);
        #1;
        chk({tag, "_ready_after"}, int'(cmd_ready), 1);
        chk({tag, "_ndone"}, done_q.size(), 1);
    endtask

    initial begin
        int acc, acc2, d, d2, maxa, n_done;
        int exp_wrap[4];
        int exp_b2b[3];
        bit hit;
        exp_wrap = '{638, 639, 1278, 1279};
        exp_b2b  = '{0, 1, 3202};

        // Reset state
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;

        // Single pixel
        single_pixel("single");

        // Row wrap at the right edge
        clear_log();
        issue(638, 639, 0, 1, 'h0F0, 1'b0, acc);
        wait_done(d);
        chk("wrap_nwr", wr_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_addr%0d", i), wr_addr.size() > i ? wr_addr[i] : -1, exp_wrap[i]);
            chk($sformatf("wrap_cyc%0d", i), wr_cyc.size() > i ? wr_cyc[i] - acc : -1, 2 + i);
        end
        chk("wrap_data", wr_data.size() > 3 ? wr_data[3] : -1, 'h00F0);
        chk("wrap_done_lat", d - acc, 6);

        // Clipping to the bottom-right corner: 10x10 pixels survive
        clear_log();
        issue(630, 1000, 470, 511, 'h00F, 1'b0, acc);
        wait_done(d);
        chk("clip_nwr", wr_addr.size(), 100);
        chk("clip_first", wr_addr.size() > 0 ? wr_addr[0] : -1, 301430);
        chk("clip_last", wr_addr.size() > 0 ? wr_addr[wr_addr.size() - 1] : -1, 307199);
        maxa = 0;
        foreach (wr_addr[i]) if (wr_addr[i] > maxa) maxa = wr_addr[i];
        chk("clip_max", maxa, 307199);
        chk("clip_done_lat", d - acc, 102);

        // Empty: inverted x
        clear_log();
        issue(5, 4, 0, 0, 'hFFF, 1'b0, acc);
        wait_done(d);
        chk("empty_inv_nwr", wr_addr.size(), 0);
        chk("empty_inv_done_lat", d - acc, 2);
        @(negedge clk);
        #1;
        chk("empty_inv_ready", int'(cmd_ready), 1);

        // Empty: x0 off-screen
        clear_log();
        issue(700, 710, 0, 3, 'hFFF, 1'b0, acc);
        wait_done(d);
        chk("empty_off_nwr", wr_addr.size(), 0);
        chk("empty_off_done_lat", d - acc, 2);
        @(negedge clk);
        #1;
        chk("empty_off_ready", int'(cmd_ready), 1);

        // Back-to-back with cmd_valid held high
        clear_log();
        issue(0, 1, 0, 0, 'hABC, 1'b1, acc);
        cmd_x0 = 10'd2;
        cmd_x1 = 10'd2;
        cmd_y0 = 9'd5;
        cmd_y1 = 9'd5;
        cmd_color = 12'h555;
        wait_done(d);
        @(negedge clk);
        #1;
        chk("b2b_ready", int'(cmd_ready), 1);
        acc2 = cyc;
        chk("b2b_gap", acc2 - d, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("b2b_busy2", int'(busy), 1);
        wait_done(d2);
        chk("b2b_done2_lat", d2 - acc2, 3);
        chk("b2b_nwr", wr_addr.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_addr%0d", i), wr_addr.size() > i ? wr_addr[i] : -1, exp_b2b[i]);
        chk("b2b_data2", wr_data.size() > 2 ? wr_data[2] : -1, 'h0555);

        // cmd_valid pulse while busy is dropped
        clear_log();
        issue(10, 12, 10, 12, 'h321, 1'b0, acc);
        @(negedge clk);
        cmd_x0 = 10'd600;
        cmd_x1 = 10'd600;
        cmd_y0 = 9'd400;
        cmd_y1 = 9'd400;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(d);
        repeat (4) @(negedge clk);
        #1;
        chk("pulse_nwr", wr_addr.size(), 9);
        hit = 1'b0;
        foreach (wr_addr[i]) if (wr_addr[i] == 256600) hit = 1'b1;
        chk("pulse_no_write", int'(hit), 0);
        chk("pulse_ndone", done_q.size(), 1);
        chk("pulse_idle", int'(busy), 0);

        // Reset in the middle of a 10x10 fill after 37 writes
        clear_log();
        issue(0, 9, 0, 9, 'h123, 1'b0, acc);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #2;
            if (wr_addr.size() >= 37) break;
        end
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        n_done = done_q.size();
        repeat (3) @(negedge clk);
        chk("midrst_nwr", wr_addr.size(), 37);
        chk("midrst_last", wr_addr.size() > 0 ? wr_addr[wr_addr.size() - 1] : -1, 1926);
        chk("midrst_ndone", n_done, 0);
        chk("midrst_we_held", int'(mem_we), 0);
        rstn = 1'b1;

        // Normal command after the aborted one
        single_pixel("post_rst");

        chk("en_eq_we", en_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
